// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter sharing one GMII transmit port between two frame senders,
// with a 1-cycle registered datapath, enforced inter-frame gap and start/length watchdogs.
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 64,
  parameter int MAX_FRAME     = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       src0_req,
  output logic       src0_gnt,
  input  logic       src0_txctl,
  input  logic [7:0] src0_txd,
  input  logic       src1_req,
  output logic       src1_gnt,
  input  logic       src1_txctl,
  input  logic [7:0] src1_txd,
  output logic       gmii_txctl,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overlong
);

  if (START_TIMEOUT < 1 || START_TIMEOUT > 256) begin : g_bad_start_timeout
    $error("START_TIMEOUT must be 1..256 to fit the 8-bit timer");
  end
  if (IFG_CYCLES < 1 || IFG_CYCLES > 32) begin : g_bad_ifg
    $error("IFG_CYCLES must be 1..32 to fit the 5-bit gap counter");
  end
  if (MAX_FRAME < 1 || MAX_FRAME > 4095) begin : g_bad_max_frame
    $error("MAX_FRAME must be 1..4095 to fit the 12-bit length counter");
  end

  localparam logic [7:0]  TIMER_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [4:0]  GAP_LAST   = 5'(IFG_CYCLES - 1);
  localparam logic [11:0] LEN_MAX    = 12'(MAX_FRAME);

  typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, GAP} state_t;

  state_t      state_reg, state_next;
  logic        sel_reg, sel_next;
  logic        last_served_reg, last_served_next;
  logic [7:0]  timer_reg, timer_next;
  logic [4:0]  gap_cnt_reg, gap_cnt_next;
  logic [11:0] len_reg, len_next;
  logic [1:0]  gnt_reg, gnt_next;
  logic        txctl_reg, txctl_next;
  logic [7:0]  txd_reg, txd_next;
  logic        err_timeout_reg, err_timeout_next;
  logic        err_overlong_reg, err_overlong_next;
  logic        pick;

  // Only the granted source is ever looked at; the other one is muxed away here.
  logic        cur_req, cur_txctl;
  logic [7:0]  cur_txd;
  assign cur_req   = sel_reg ? src1_req   : src0_req;
  assign cur_txctl = sel_reg ? src1_txctl : src0_txctl;
  assign cur_txd   = sel_reg ? src1_txd   : src0_txd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      sel_reg          <= 1'b0;
      last_served_reg  <= 1'b1;
      timer_reg        <= '0;
      gap_cnt_reg      <= '0;
      len_reg          <= '0;
      gnt_reg          <= '0;
      txctl_reg        <= 1'b0;
      txd_reg          <= '0;
      err_timeout_reg  <= 1'b0;
      err_overlong_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sel_reg          <= sel_next;
      last_served_reg  <= last_served_next;
      timer_reg        <= timer_next;
      gap_cnt_reg      <= gap_cnt_next;
      len_reg          <= len_next;
      gnt_reg          <= gnt_next;
      txctl_reg        <= txctl_next;
      txd_reg          <= txd_next;
      err_timeout_reg  <= err_timeout_next;
      err_overlong_reg <= err_overlong_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    sel_next          = sel_reg;
    last_served_next  = last_served_reg;
    timer_next        = timer_reg;
    gap_cnt_next      = gap_cnt_reg;
    len_next          = len_reg;
    gnt_next          = gnt_reg;
    txctl_next        = 1'b0;
    txd_next          = '0;
    err_timeout_next  = 1'b0;
    err_overlong_next = 1'b0;
    pick              = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable && (src0_req || src1_req)) begin
          // On a tie the source that was not served last wins.
          pick             = (src0_req && src1_req) ? ~last_served_reg : src1_req;
          sel_next         = pick;
          last_served_next = pick;
          timer_next       = '0;
          gnt_next         = pick ? 2'b10 : 2'b01;
          state_next       = GRANT;
        end
      end
      GRANT: begin
        txctl_next = cur_txctl;
        txd_next   = cur_txd;
        if (cur_txctl) begin
          len_next   = 12'd1;
          state_next = ACTIVE;
        end else if (!cur_req) begin
          gnt_next   = '0;
          state_next = IDLE;
        end else if (timer_reg == TIMER_LAST) begin
          err_timeout_next = 1'b1;
          gnt_next         = '0;
          gap_cnt_next     = '0;
          state_next       = GAP;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      ACTIVE: begin
        if (!cur_txctl) begin
          txd_next     = cur_txd;
          gnt_next     = '0;
          gap_cnt_next = '0;
          state_next   = GAP;
        end else if (len_reg == LEN_MAX) begin
          // Truncate: txctl drops mid-frame so the PHY emits a bad CRC.
          err_overlong_next = 1'b1;
          gnt_next          = '0;
          gap_cnt_next      = '0;
          state_next        = GAP;
        end else begin
          txctl_next = 1'b1;
          txd_next   = cur_txd;
          len_next   = len_reg + 12'd1;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 5'd1;
        end
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign src0_gnt     = gnt_reg[0];
  assign src1_gnt     = gnt_reg[1];
  assign gmii_txctl   = txctl_reg;
  assign gmii_txd     = txd_reg;
  assign busy         = (state_reg != IDLE);
  assign err_timeout  = err_timeout_reg;
  assign err_overlong = err_overlong_reg;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: inputs change and outputs are sampled on the
// falling clock edge; expected values are hand-derived cycle counts and data patterns.
module tb_gmii_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic       src0_req, src0_txctl, src1_req, src1_txctl;
  logic [7:0] src0_txd, src1_txd;
  logic       src0_gnt, src1_gnt, gmii_txctl, busy, err_timeout, err_overlong;
  logic [7:0] gmii_txd;

  int checks = 0;
  int errors = 0;

  always #4 clk = ~clk;

  gmii_tx_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .src0_req     (src0_req),
    .src0_gnt     (src0_gnt),
    .src0_txctl   (src0_txctl),
    .src0_txd     (src0_txd),
    .src1_req     (src1_req),
    .src1_gnt     (src1_gnt),
    .src1_txctl   (src1_txctl),
    .src1_txd     (src1_txd),
    .gmii_txctl   (gmii_txctl),
    .gmii_txd     (gmii_txd),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_overlong (err_overlong)
  );

  task automatic set_src(input int s, input logic ctl, input logic [7:0] d);
    if (s == 0) begin src0_txctl = ctl; src0_txd = d; end
    else        begin src1_txctl = ctl; src1_txd = d; end
  endtask

  task automatic set_req(input int s, input logic r);
    if (s == 0) src0_req = r; else src1_req = r;
  endtask

  // Returns which source got a grant and how many falling edges that took (-1 on timeout).
  task automatic wait_any_gnt(output int who, output int waited);
    who = -1;
    waited = 0;
    while (who < 0 && waited < 300) begin
      @(negedge clk);
      waited++;
      if (src0_gnt) who = 0;
      else if (src1_gnt) who = 1;
    end
  endtask

  // Called on the falling edge where src s is first seen granted. Sends n bytes after
  // `delay` idle cycles: 7x 0x55, 0xD5, then seed+k. Counts gmii cycles that differ
  // from the one-cycle-delayed source bytes.
  task automatic drive_frame(input int s, input int delay, input int n, input logic [7:0] seed,
                             input bit drop_req, input bit noise, input int en_off_at,
                             output int hi, output int bad, output logic gnt_after);
    logic       on;
    logic [7:0] d;
    int         k;
    hi = 0;
    bad = 0;
    for (int c = 0; c <= delay + n; c++) begin
      k  = c - delay;
      on = (c >= delay) && (c < delay + n);
      if (!on)        d = 8'h00;
      else if (k < 7) d = 8'h55;
      else if (k == 7) d = 8'hD5;
      else            d = seed + 8'(k);
      set_src(s, on, d);
      if (on && drop_req && k == 0) set_req(s, 1'b0);
      if (noise) set_src(1 - s, c[0], 8'hA0 ^ 8'(c));
      if (c == en_off_at) enable = 1'b0;
      @(negedge clk);
      if (gmii_txctl !== on || gmii_txd !== d) bad++;
      if (gmii_txctl) hi++;
    end
    set_src(s, 1'b0, 8'h00);
    if (noise) set_src(1 - s, 1'b0, 8'h00);
    gnt_after = (s == 0) ? src0_gnt : src1_gnt;
  endtask

  // Counts falling edges with busy high, starting with the current one.
  task automatic gap_wait(output int n, output int to_p, output int ol_p);
    n = 0;
    to_p = 0;
    ol_p = 0;
    while (busy && n < 100) begin
      if (err_timeout) to_p++;
      if (err_overlong) ol_p++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1;
    src0_req = 1'b1; src1_req = 1'b0;
    set_src(0, 1'b1, 8'hFF); set_src(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({src0_gnt, src1_gnt, gmii_txctl, busy, err_timeout, err_overlong} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {src0_gnt, src1_gnt, gmii_txctl, busy, err_timeout, err_overlong});
    end
    checks++;
    if (gmii_txd !== 8'h00) begin errors++; $display("FAIL reset_txd: got %h want 00", gmii_txd); end
    src0_req = 1'b0; set_src(0, 1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int who, waited, hi, bad, n, to_p, ol_p;
    logic ga;
    src0_req = 1'b1;
    wait_any_gnt(who, waited);
    checks++;
    if (who !== 0 || waited !== 1) begin
      errors++; $display("FAIL single_gnt: got src %0d after %0d want src 0 after 1", who, waited);
    end
    drive_frame(0, 3, 72, 8'h10, 1'b1, 1'b0, -1, hi, bad, ga);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL single_data: %0d bad cycles want 0", bad); end
    checks++;
    if (hi !== 72) begin errors++; $display("FAIL single_len: got %0d txctl cycles want 72", hi); end
    checks++;
    if (ga !== 1'b0) begin errors++; $display("FAIL single_gnt_drop: got %b want 0", ga); end
    gap_wait(n, to_p, ol_p);
    checks++;
    if (n !== 12 || to_p !== 0 || ol_p !== 0) begin
      errors++; $display("FAIL single_gap: busy %0d cycles, pulses %0d/%0d want 12, 0/0", n, to_p, ol_p);
    end
  endtask

  task automatic test_round_robin();
    int who, waited, hi, bad;
    logic ga;
    rst_n = 1'b0;
    src0_req = 1'b1; src1_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_any_gnt(who, waited);
      checks++;
      if (who !== f % 2) begin errors++; $display("FAIL rr_order%0d: got src %0d want %0d", f, who, f % 2); end
      if (f > 0) begin
        checks++;
        if (1 + waited < 14) begin errors++; $display("FAIL rr_spacing%0d: got %0d low cycles want >=14", f, 1 + waited); end
      end
      if (who < 0) break;
      drive_frame(who, 0, 100, 8'(8'h40 + f), 1'b0, 1'b0, -1, hi, bad, ga);
      checks++;
      if (bad !== 0 || hi !== 100) begin
        errors++; $display("FAIL rr_frame%0d: %0d bad, %0d high, want 0, 100", f, bad, hi);
      end
    end
    src0_req = 1'b0; src1_req = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
  endtask

  task automatic test_start_timeout();
    int who, waited, cnt, n, to_p, ol_p, hi, bad;
    logic ga;
    src1_req = 1'b1;
    wait_any_gnt(who, waited);
    checks++;
    if (who !== 1) begin errors++; $display("FAIL to_gnt: got src %0d want 1", who); end
    src0_req = 1'b1;
    cnt = 0;
    while (!err_timeout && cnt < 200) begin @(negedge clk); cnt++; end
    checks++;
    if (cnt !== 64) begin errors++; $display("FAIL to_cycle: pulse after %0d cycles want 64", cnt); end
    checks++;
    if (src1_gnt !== 1'b0) begin errors++; $display("FAIL to_gnt_drop: got %b want 0", src1_gnt); end
    src1_req = 1'b0;
    gap_wait(n, to_p, ol_p);
    checks++;
    if (n !== 12 || to_p !== 1) begin
      errors++; $display("FAIL to_gap: busy %0d cycles, %0d pulses want 12, 1", n, to_p);
    end
    wait_any_gnt(who, waited);
    checks++;
    if (who !== 0 || waited !== 1) begin
      errors++; $display("FAIL to_next: got src %0d after %0d want src 0 after 1", who, waited);
    end
    drive_frame(0, 1, 20, 8'h80, 1'b1, 1'b0, -1, hi, bad, ga);
    gap_wait(n, to_p, ol_p);
  endtask

  task automatic test_overlong();
    int who, waited, hi, bad, err_at, ol_cnt, gnt1_at, n, to_p, ol_p;
    logic ga;
    src0_req = 1'b1;
    wait_any_gnt(who, waited);
    checks++;
    if (who !== 0) begin errors++; $display("FAIL ol_gnt: got src %0d want 0", who); end
    src1_req = 1'b1;
    hi = 0; err_at = -1; ol_cnt = 0; gnt1_at = -1;
    for (int c = 0; c < 2000 && gnt1_at < 0; c++) begin
      set_src(0, 1'b1, 8'(c));
      if (c == 0) src0_req = 1'b0;
      @(negedge clk);
      if (gmii_txctl) hi++;
      if (err_overlong) begin ol_cnt++; if (err_at < 0) err_at = c; end
      if (src1_gnt) gnt1_at = c;
    end
    set_src(0, 1'b0, 8'h00);
    checks++;
    if (hi !== 1600) begin errors++; $display("FAIL ol_len: got %0d txctl cycles want 1600", hi); end
    checks++;
    if (err_at !== 1600 || ol_cnt !== 1) begin
      errors++; $display("FAIL ol_pulse: at %0d count %0d want 1600, 1", err_at, ol_cnt);
    end
    checks++;
    if (gnt1_at !== 1613) begin errors++; $display("FAIL ol_next_gnt: at %0d want 1613", gnt1_at); end
    if (gnt1_at >= 0) begin
      drive_frame(1, 2, 30, 8'h20, 1'b1, 1'b0, -1, hi, bad, ga);
      checks++;
      if (bad !== 0 || hi !== 30) begin
        errors++; $display("FAIL ol_src1_frame: %0d bad, %0d high, want 0, 30", bad, hi);
      end
    end
    gap_wait(n, to_p, ol_p);
  endtask

  task automatic test_interference_enable();
    int who, waited, hi, bad, n, to_p, ol_p, stray;
    logic ga;
    src0_req = 1'b1;
    wait_any_gnt(who, waited);
    checks++;
    if (who !== 0) begin errors++; $display("FAIL if_gnt: got src %0d want 0", who); end
    src1_req = 1'b1;
    drive_frame(0, 1, 60, 8'hC0, 1'b1, 1'b1, 20, hi, bad, ga);
    checks++;
    if (bad !== 0 || hi !== 60) begin
      errors++; $display("FAIL if_frame: %0d bad, %0d high, want 0, 60", bad, hi);
    end
    gap_wait(n, to_p, ol_p);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL if_gap: busy %0d cycles want 12", n); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (src0_gnt || src1_gnt || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL en_hold: %0d granted cycles want 0", stray); end
    enable = 1'b1;
    wait_any_gnt(who, waited);
    checks++;
    if (who !== 1 || waited !== 1) begin
      errors++; $display("FAIL en_resume: got src %0d after %0d want src 1 after 1", who, waited);
    end
    drive_frame(1, 0, 16, 8'h00, 1'b1, 1'b0, -1, hi, bad, ga);
    gap_wait(n, to_p, ol_p);
  endtask

  task automatic test_reset_mid_frame();
    int who, waited, hi, bad, n, to_p, ol_p;
    logic ga;
    src0_req = 1'b1;
    wait_any_gnt(who, waited);
    src1_req = 1'b1;
    hi = 0;
    for (int c = 0; c <= 40; c++) begin
      set_src(0, 1'b1, 8'(c + 3));
      if (c == 0) src0_req = 1'b0;
      if (c == 40) rst_n = 1'b0;
      @(negedge clk);
      if (c < 40 && gmii_txctl) hi++;
    end
    checks++;
    if (hi !== 40) begin errors++; $display("FAIL rst_pre: got %0d txctl cycles want 40", hi); end
    checks++;
    if ({gmii_txctl, src0_gnt, src1_gnt, busy} !== 4'b0) begin
      errors++; $display("FAIL rst_mid: got %b want 0000", {gmii_txctl, src0_gnt, src1_gnt, busy});
    end
    set_src(0, 1'b0, 8'h00);
    src0_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_any_gnt(who, waited);
    checks++;
    if (who !== 0 || waited !== 1) begin
      errors++; $display("FAIL rst_tie: got src %0d after %0d want src 0 after 1", who, waited);
    end
    if (who == 0) begin
      drive_frame(0, 0, 10, 8'h60, 1'b1, 1'b0, -1, hi, bad, ga);
      gap_wait(n, to_p, ol_p);
      wait_any_gnt(who, waited);
      checks++;
      if (who !== 1) begin errors++; $display("FAIL rst_then_src1: got src %0d want 1", who); end
      if (who == 1) drive_frame(1, 0, 10, 8'h70, 1'b1, 1'b0, -1, hi, bad, ga);
    end
    src0_req = 1'b0; src1_req = 1'b0;
    gap_wait(n, to_p, ol_p);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_start_timeout();
    test_overlong();
    test_interference_enable();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete within 1 ms");
    $fatal(1);
  end

endmodule
